// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port command memory between two requesters.
// One memory transaction in flight at a time; the winner gets a one-cycle Done pulse.
//
// state | meaning
// IDLE  | no transaction; requests sampled, winner's command captured
// ISSUE | MemEn strobe for the captured command
// WAIT  | read latency countdown; read data captured when count reaches 1
// DONE  | Done pulse to the winner; winner becomes last-granted
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Req0,
    input  logic                  RW0,
    input  logic [ADDR_WIDTH-1:0] Addr0,
    input  logic [DATA_WIDTH-1:0] WrData0,
    output logic                  Gnt0,
    output logic                  Done0,
    output logic [DATA_WIDTH-1:0] RdData0,
    input  logic                  Req1,
    input  logic                  RW1,
    input  logic [ADDR_WIDTH-1:0] Addr1,
    input  logic [DATA_WIDTH-1:0] WrData1,
    output logic                  Gnt1,
    output logic                  Done1,
    output logic [DATA_WIDTH-1:0] RdData1,
    output logic                  MemEn,
    output logic                  MemRW,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWrData,
    input  logic [DATA_WIDTH-1:0] MemRdData,
    output logic                  Busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  pick;
    logic                  win_q, last_q;
    logic                  cmd_rw_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [DATA_WIDTH-1:0] cmd_wdata_q;
    logic [2:0]            cnt_q;
    logic                  gnt0_q, gnt1_q, busy_q;
    logic [DATA_WIDTH-1:0] rd0_q, rd1_q;
    logic                  mem_en, done0, done1;

    // A lone requester always wins; on a tie the port not granted last goes first.
    assign pick = (Req0 && Req1) ? ~last_q : Req1;

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Req0 || Req1) state_d = S_ISSUE;
            S_ISSUE: state_d = cmd_rw_q ? S_DONE : S_WAIT;
            S_WAIT:  if (cnt_q == 3'd1) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_en = (state_q == S_ISSUE);
        done0  = (state_q == S_DONE) && !win_q;
        done1  = (state_q == S_DONE) &&  win_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            win_q       <= 1'b0;
            last_q      <= 1'b1;
            cmd_rw_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cnt_q       <= 3'd0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            busy_q      <= 1'b0;
            rd0_q       <= '0;
            rd1_q       <= '0;
        end else begin
            busy_q <= (state_d != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (Req0 || Req1) begin
                        win_q       <= pick;
                        cmd_rw_q    <= pick ? RW1     : RW0;
                        cmd_addr_q  <= pick ? Addr1   : Addr0;
                        cmd_wdata_q <= pick ? WrData1 : WrData0;
                        gnt0_q      <= ~pick;
                        gnt1_q      <= pick;
                    end
                end
                S_ISSUE: begin
                    if (!cmd_rw_q) cnt_q <= 3'(RD_LATENCY);
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        if (win_q) rd1_q <= MemRdData;
                        else       rd0_q <= MemRdData;
                    end
                end
                S_DONE: begin
                    last_q <= win_q;
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign Gnt0      = gnt0_q;
    assign Gnt1      = gnt1_q;
    assign Done0     = done0;
    assign Done1     = done1;
    assign RdData0   = rd0_q;
    assign RdData1   = rd1_q;
    assign MemEn     = mem_en;
    assign MemRW     = cmd_rw_q;
    assign MemAddr   = cmd_addr_q;
    assign MemWrData = cmd_wdata_q;
    assign Busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, every cycle
// compared against a transaction-timeline reference model.
module tb_mem_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int L  = 3;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Req0, RW0, Req1, RW1;
    logic [AW-1:0] Addr0, Addr1;
    logic [DW-1:0] WrData0, WrData1;
    logic          Gnt0, Done0, Gnt1, Done1;
    logic [DW-1:0] RdData0, RdData1;
    logic          MemEn, MemRW;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] MemWrData, MemRdData;
    logic          Busy;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .RW0(RW0), .Addr0(Addr0), .WrData0(WrData0),
        .Gnt0(Gnt0), .Done0(Done0), .RdData0(RdData0),
        .Req1(Req1), .RW1(RW1), .Addr1(Addr1), .WrData1(WrData1),
        .Gnt1(Gnt1), .Done1(Done1), .RdData1(RdData1),
        .MemEn(MemEn), .MemRW(MemRW), .MemAddr(MemAddr), .MemWrData(MemWrData),
        .MemRdData(MemRdData), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] init_val(int a);
        return (a == 8'h12) ? 8'h3C : 8'(a * 7 + 3);
    endfunction

    // Memory macro: read data valid L cycles after the MemEn cycle, garbage otherwise.
    bit   [7:0] mac [256];
    bit         wrt [256];
    logic [7:0] pipe [L];
    always @(posedge Clk) begin
        if (MemEn === 1'b1 && MemRW === 1'b1) begin
            mac[MemAddr] <= MemWrData;
            wrt[MemAddr] <= 1'b1;
        end
        if (MemEn === 1'b1 && MemRW === 1'b0)
            pipe[0] <= wrt[MemAddr] ? mac[MemAddr] : init_val(int'(MemAddr));
        else
            pipe[0] <= 8'($urandom);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign MemRdData = pipe[L-1];

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;

    // reference model: one transaction occupies cycles t0+1 .. t0+dur
    bit         m_busy = 0;
    int         m_t0 = 0, m_dur = 0, m_win = 0, m_last = 1;
    logic       m_rw;
    logic [7:0] m_addr, m_wd;
    logic [7:0] rd_exp [2];
    logic [7:0] ref_mem [256];

    int         rem [2];
    bit         inflight [2];
    bit         keep_req = 1, rnd_mode = 0, rst_next = 0;
    logic       f_rw [2];
    logic [7:0] f_addr [2], f_wd [2];
    logic       req_v [2], rw_v [2];
    logic [7:0] addr_v [2], wd_v [2];

    int en_cyc = 0, en_cnt = 0;
    int d_cyc [2], d_cnt [2];
    int grant_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        bit in_txn, e_en;
        bit e_g [2];
        bit e_d [2];
        @(negedge Clk);
        in_txn = m_busy && (cyc > m_t0) && (cyc <= m_t0 + m_dur);
        e_en   = in_txn && (cyc == m_t0 + 1);
        for (int p = 0; p < 2; p++) begin
            e_g[p] = in_txn && (m_win == p);
            e_d[p] = e_g[p] && (cyc == m_t0 + m_dur);
        end
        if (in_txn && cyc == m_t0 + m_dur) begin
            if (m_rw) ref_mem[m_addr] = m_wd;
            else      rd_exp[m_win] = ref_mem[m_addr];
        end
        chk("Gnt0", Gnt0, e_g[0]);
        chk("Gnt1", Gnt1, e_g[1]);
        chk("Done0", Done0, e_d[0]);
        chk("Done1", Done1, e_d[1]);
        chk("MemEn", MemEn, e_en);
        chk("Busy", Busy, in_txn);
        chk("RdData0", RdData0, rd_exp[0]);
        chk("RdData1", RdData1, rd_exp[1]);
        if (e_en) begin
            chk("MemRW", MemRW, m_rw);
            chk("MemAddr", MemAddr, m_addr);
            if (m_rw) chk("MemWrData", MemWrData, m_wd);
        end
        if (MemEn === 1'b1) begin
            en_cyc = cyc;
            en_cnt++;
            grant_log.push_back((Gnt1 === 1'b1) ? 1 : 0);
        end
        if (Done0 === 1'b1) begin d_cnt[0]++; d_cyc[0] = cyc; end
        if (Done1 === 1'b1) begin d_cnt[1]++; d_cyc[1] = cyc; end

        for (int p = 0; p < 2; p++) begin
            if (e_d[p]) begin rem[p]--; inflight[p] = 0; end
            if (rnd_mode && !inflight[p] && rem[p] == 0 && $urandom_range(2) == 0) begin
                rem[p]    = 1;
                f_rw[p]   = 1'($urandom);
                f_addr[p] = 8'($urandom_range(0, 15));
                f_wd[p]   = 8'($urandom);
            end
            if (inflight[p]) begin
                if (rnd_mode) begin
                    req_v[p]  = 1'($urandom);
                    rw_v[p]   = 1'($urandom);
                    addr_v[p] = 8'($urandom);
                    wd_v[p]   = 8'($urandom);
                end else begin
                    req_v[p] = keep_req;
                end
            end else if (rem[p] > 0) begin
                req_v[p]  = 1'b1;
                rw_v[p]   = f_rw[p];
                addr_v[p] = f_addr[p];
                wd_v[p]   = f_wd[p];
            end else begin
                req_v[p] = 1'b0;
            end
        end
        Reset   = rst_next;
        Req0    = req_v[0]; RW0 = rw_v[0]; Addr0 = addr_v[0]; WrData0 = wd_v[0];
        Req1    = req_v[1]; RW1 = rw_v[1]; Addr1 = addr_v[1]; WrData1 = wd_v[1];

        if (rst_next) begin
            m_busy = 0;
            m_last = 1;
            for (int p = 0; p < 2; p++) begin
                rd_exp[p] = 8'h00; inflight[p] = 0; rem[p] = 0;
            end
        end else begin
            if (m_busy && cyc > m_t0 + m_dur) m_busy = 0;
            if (!m_busy && (req_v[0] || req_v[1])) begin
                m_win  = (req_v[0] && req_v[1]) ? 1 - m_last : (req_v[1] ? 1 : 0);
                m_last = m_win;
                m_busy = 1;
                m_t0   = cyc;
                m_rw   = rw_v[m_win];
                m_addr = addr_v[m_win];
                m_wd   = wd_v[m_win];
                m_dur  = m_rw ? 2 : 2 + L;
                inflight[m_win] = 1;
            end
        end
        cyc++;
    endtask

    task automatic run_until_idle(input int maxc);
        int k = 0;
        while (k < maxc && !(rem[0] == 0 && rem[1] == 0 && (!m_busy || cyc > m_t0 + m_dur))) begin
            step();
            k++;
        end
        chk("run_bound", k < maxc, 1'b1);
    endtask

    task automatic do_reset(input int n);
        rst_next = 1;
        repeat (n) step();
        rst_next = 0;
    endtask

    task automatic chk_reset_values();
        chk("rst_Gnt0", Gnt0, 0);       chk("rst_Gnt1", Gnt1, 0);
        chk("rst_Done0", Done0, 0);     chk("rst_Done1", Done1, 0);
        chk("rst_MemEn", MemEn, 0);     chk("rst_MemRW", MemRW, 0);
        chk("rst_MemAddr", MemAddr, 0); chk("rst_MemWrData", MemWrData, 0);
        chk("rst_RdData0", RdData0, 0); chk("rst_RdData1", RdData1, 0);
        chk("rst_Busy", Busy, 0);
    endtask

    initial begin
        int rq;
        Reset = 1'b1;
        Req0 = 0; RW0 = 0; Addr0 = 0; WrData0 = 0;
        Req1 = 0; RW1 = 0; Addr1 = 0; WrData1 = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        for (int p = 0; p < 2; p++) begin
            rem[p] = 0; inflight[p] = 0; rd_exp[p] = 8'h00; d_cyc[p] = 0; d_cnt[p] = 0;
            f_rw[p] = 0; f_addr[p] = 0; f_wd[p] = 0;
            req_v[p] = 0; rw_v[p] = 0; addr_v[p] = 0; wd_v[p] = 0;
        end

        do_reset(3);
        step();
        chk_reset_values();

        // port 1 read of 0x12
        f_rw[1] = 0; f_addr[1] = 8'h12; rem[1] = 1;
        rq = cyc;
        run_until_idle(30);
        chk("rd_memen_lat", en_cyc - rq, 1);
        chk("rd_done1_lat", d_cyc[1] - rq, 2 + L);
        step();
        chk("rd_RdData1", RdData1, 8'h3C);
        chk("rd_RdData0_untouched", RdData0, 8'h00);

        // port 0 write 0xA5 to 0x12, then read it back
        f_rw[0] = 1; f_addr[0] = 8'h12; f_wd[0] = 8'hA5; rem[0] = 1;
        rq = cyc;
        run_until_idle(30);
        chk("wr_memen_lat", en_cyc - rq, 1);
        chk("wr_done0_lat", d_cyc[0] - rq, 2);
        chk("wr_RdData0_untouched", RdData0, 8'h00);
        f_rw[0] = 0; rem[0] = 1;
        run_until_idle(30);
        step();
        chk("rb_RdData0", RdData0, 8'hA5);
        chk("rb_RdData1_held", RdData1, 8'h3C);

        // both ports requesting continuously from reset
        do_reset(2);
        grant_log.delete();
        f_rw[0] = 1; f_addr[0] = 8'h20; f_wd[0] = 8'h11; rem[0] = 2;
        f_rw[1] = 1; f_addr[1] = 8'h21; f_wd[1] = 8'h22; rem[1] = 2;
        run_until_idle(60);
        chk("rr_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            chk("rr_g0", grant_log[0], 0);
            chk("rr_g1", grant_log[1], 1);
            chk("rr_g2", grant_log[2], 0);
            chk("rr_g3", grant_log[3], 1);
        end

        // one-cycle request pulse still completes exactly once
        keep_req = 0; en_cnt = 0; d_cnt[0] = 0;
        f_rw[0] = 0; f_addr[0] = 8'h40; rem[0] = 1;
        run_until_idle(30);
        repeat (6) step();
        chk("drop_done0_count", d_cnt[0], 1);
        chk("drop_memen_count", en_cnt, 1);
        keep_req = 1;

        // reset during WAIT aborts the read
        f_rw[0] = 0; f_addr[0] = 8'h12; rem[0] = 1;
        rq = cyc;
        step(); step();
        chk("abort_in_wait", Busy, 1'b1);
        d_cnt[0] = 0;
        do_reset(1);
        step();
        chk("abort_Busy", Busy, 0);
        chk("abort_Gnt0", Gnt0, 0);
        chk("abort_MemEn", MemEn, 0);
        repeat (6) step();
        chk("abort_no_done0", d_cnt[0], 0);
        grant_log.delete();
        f_rw[0] = 1; f_addr[0] = 8'h30; f_wd[0] = 8'h5A; rem[0] = 1;
        f_rw[1] = 1; f_addr[1] = 8'h31; f_wd[1] = 8'h6B; rem[1] = 1;
        run_until_idle(40);
        chk("abort_tie_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);

        // lone requester keeps winning
        grant_log.delete();
        f_rw[1] = 0; f_addr[1] = 8'h30; rem[1] = 3;
        run_until_idle(60);
        chk("lone_count", grant_log.size(), 3);
        for (int i = 0; i < grant_log.size(); i++) chk("lone_port1", grant_log[i], 1);

        // random traffic
        rnd_mode = 1;
        repeat (400) step();
        rnd_mode = 0;
        run_until_idle(60);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
